// File: rtl/axi4_fb_rd_slv.sv
// Read-only AXI4 slave serving INCR/FIXED 64-bit read bursts from a synchronous framebuffer SRAM.
// A 2-entry output buffer keeps one beat per clock flowing under rready backpressure.
module axi4_fb_rd_slv #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_AW     = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   input  logic [7:0]            arlen_i,
   input  logic [2:0]            arsize_i,
   input  logic [1:0]            arburst_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [ID_WIDTH-1:0]   rid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic                  mem_en_o,
   output logic [MEM_AW-1:0]     mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q;
   logic [MEM_AW-1:0]     addr_q;
   logic [8:0]            issue_cnt_q;
   logic [8:0]            beat_cnt_q;
   logic                  fixed_q;
   logic                  err_q;
   logic [1:0]            resp_q;
   logic                  in_flight_q;

   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            fifo_cnt_q;

   logic                  ar_hs, pop, push, issue;
   logic                  ar_oor, ar_bad;
   logic [1:0]            ar_resp;
   logic [2:0]            occ;

   // Response is decided once per burst from the request fields.
   assign ar_oor  = (araddr_i >> (MEM_AW + 3)) != '0;
   assign ar_bad  = (arsize_i != 3'd3) || arburst_i[1];
   assign ar_resp = ar_oor ? RESP_DECERR : (ar_bad ? RESP_SLVERR : RESP_OKAY);

   assign arready_o = (state_q == S_IDLE) && !rst_i;
   assign ar_hs     = arready_o && arvalid_i;
   assign rvalid_o  = fifo_cnt_q != 2'd0;
   assign pop       = rvalid_o && rready_i;
   assign push      = in_flight_q;

   // Buffer slots already committed: stored beats plus the read in flight, less this cycle's pop.
   assign occ   = {1'b0, fifo_cnt_q} + {2'b00, in_flight_q} - {2'b00, pop};
   assign issue = (state_q == S_BURST) && (issue_cnt_q != 9'd0) && (occ < 3'd2) && !rst_i;

   assign mem_en_o   = issue && !err_q;
   assign mem_addr_o = addr_q;
   assign rdata_o    = rvalid_o ? fifo_mem[rd_ptr_q] : '0;
   assign rid_o      = id_q;
   assign rresp_o    = resp_q;
   assign rlast_o    = rvalid_o && (beat_cnt_q == 9'd1);
   assign busy_o     = state_q != S_IDLE;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ar_hs) state_d = S_BURST;
         S_BURST: if (pop && (beat_cnt_q == 9'd1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         fixed_q     <= 1'b0;
         err_q       <= 1'b0;
         resp_q      <= RESP_OKAY;
         in_flight_q <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fifo_cnt_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_flight_q <= issue;
         if (ar_hs) begin
            id_q        <= arid_i;
            addr_q      <= araddr_i[MEM_AW+2:3];
            issue_cnt_q <= {1'b0, arlen_i} + 9'd1;
            beat_cnt_q  <= {1'b0, arlen_i} + 9'd1;
            fixed_q     <= (arburst_i == 2'd0);
            err_q       <= (ar_resp != RESP_OKAY);
            resp_q      <= ar_resp;
         end
         if (issue) begin
            issue_cnt_q <= issue_cnt_q - 9'd1;
            if (!fixed_q) addr_q <= addr_q + 1'b1;
         end
         if (pop) begin
            beat_cnt_q <= beat_cnt_q - 9'd1;
            rd_ptr_q   <= !rd_ptr_q;
         end
         if (push) wr_ptr_q <= !wr_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: buffer storage has no reset; fifo_cnt_q gates visibility, so stale words never escape.
   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= err_q ? '0 : mem_rdata_i;
   end

endmodule

// File: tb/tb_axi4_fb_rd_slv.sv
// Directed bench for axi4_fb_rd_slv with a registered-read SRAM model and per-cycle beat checks.
module tb_axi4_fb_rd_slv;

   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int IW  = 4;
   localparam int MAW = 16;

   logic           clk = 1'b0;
   logic           rst_i;
   logic [IW-1:0]  arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           arvalid, arready;
   logic [IW-1:0]  rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast, rvalid, rready;
   logic           mem_en;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_rdata;
   logic           busy;

   logic [DW-1:0]  sram [0:(1<<MAW)-1];
   logic [DW-1:0]  sram_q;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_en) sram_q <= sram[mem_addr];
   assign mem_rdata = sram_q;

   axi4_fb_rd_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(MAW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
      .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
      .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
      .rvalid_o(rvalid), .rready_i(rready),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
      .busy_o(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Runs one burst starting at the next falling edge; stop_at > 0 returns after that many beats.
   task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp,
                            input bit bp, input int stop_at);
      logic [MAW-1:0] base, ea;
      logic [DW-1:0]  prev_data;
      logic           prev_last;
      bit             prev_stall, err, fixed;
      int             issued, beats, k, target;
      base       = addr[MAW+2:3];
      err        = exp_resp != 2'b00;
      fixed      = burst == 2'd0;
      target     = (stop_at > 0) ? stop_at : int'(len) + 1;
      issued     = 0;
      beats      = 0;
      k          = 0;
      prev_stall = 0;
      prev_data  = '0;
      prev_last  = 1'b0;
      @(negedge clk);
      rready = 1'b0;
      #1;
      check("arready_idle", 64'(arready), 64'd1);
      check("busy_idle", 64'(busy), 64'd0);
      arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
      while (beats < target && k < 2000) begin
         @(negedge clk);
         k++;
         arvalid = 1'b0;
         rready  = bp ? (k % 3 == 0) : 1'b1;
         #1;
         if (k == 1) begin
            check("busy_burst", 64'(busy), 64'd1);
            check("arready_burst", 64'(arready), 64'd0);
         end
         if (err) check("err_no_mem_en", 64'(mem_en), 64'd0);
         else if (mem_en) begin
            ea = fixed ? base : base + MAW'(issued);
            check("mem_addr", 64'(mem_addr), 64'(ea));
            if (!bp) check("issue_cycle", 64'(k), 64'(1 + issued));
            check("occupancy_lt2", 64'((issued - beats - int'(rvalid && rready)) < 2), 64'd1);
            issued++;
         end
         if (prev_stall) begin
            check("stall_valid", 64'(rvalid), 64'd1);
            check("stall_data", rdata, prev_data);
            check("stall_last", 64'(rlast), 64'(prev_last));
         end
         if (rvalid) begin
            ea = fixed ? base : base + MAW'(beats);
            check("rdata", rdata, err ? 64'd0 : sram[ea]);
            check("rid", 64'(rid), 64'(id));
            check("rresp", 64'(rresp), 64'(exp_resp));
            check("rlast", 64'(rlast), 64'(beats == int'(len)));
            if (!bp) check("beat_cycle", 64'(k), 64'(3 + beats));
            if (rready) beats++;
         end else begin
            check("rlast_idle", 64'(rlast), 64'd0);
         end
         prev_stall = rvalid && !rready;
         prev_data  = rdata;
         prev_last  = rlast;
      end
      if (beats < target) check("burst_timeout", 64'(beats), 64'(target));
      if (stop_at == 0) check("issue_total", 64'(issued), err ? 64'd0 : 64'(int'(len) + 1));
   endtask

   initial begin
      rst_i = 1'b1; arvalid = 1'b0; rready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'd1;
      for (int i = 0; i < (1 << MAW); i++)
         sram[i] = {16'hA000 ^ 16'(i), 16'(i), ~16'(i), 16'(i * 7)};
      sram[8] = 64'hDEAD_BEEF_0123_4567;

      repeat (3) @(negedge clk);
      #1;
      check("rst_arready", 64'(arready), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_i = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_arready", 64'(arready), 64'd1);
      check("post_rst_rvalid", 64'(rvalid), 64'd0);
      check("post_rst_rlast", 64'(rlast), 64'd0);
      check("post_rst_rdata", rdata, 64'd0);
      check("post_rst_rid", 64'(rid), 64'd0);
      check("post_rst_rresp", 64'(rresp), 64'd0);
      check("post_rst_mem_addr", 64'(mem_addr), 64'd0);
      check("post_rst_mem_en", 64'(mem_en), 64'd0);

      // Single beat, INCR 8, backpressured INCR 16, FIXED, WRAP, bad size, out of range, address wrap.
      run_burst(4'd5, 32'h0000_0040, 8'd0,  2'd1, 3'd3, 2'b00, 1'b0, 0);
      run_burst(4'd1, 32'h0000_0100, 8'd7,  2'd1, 3'd3, 2'b00, 1'b0, 0);
      run_burst(4'd2, 32'h0000_0200, 8'd15, 2'd1, 3'd3, 2'b00, 1'b1, 0);
      run_burst(4'd3, 32'h0000_0018, 8'd3,  2'd0, 3'd3, 2'b00, 1'b0, 0);
      run_burst(4'd4, 32'h0000_0080, 8'd3,  2'd2, 3'd3, 2'b10, 1'b0, 0);
      run_burst(4'd6, 32'h0000_0080, 8'd1,  2'd1, 3'd2, 2'b10, 1'b1, 0);
      run_burst(4'd7, 32'h0008_0000, 8'd1,  2'd1, 3'd3, 2'b11, 1'b0, 0);
      run_burst(4'd8, 32'h0007_FFF8, 8'd1,  2'd1, 3'd3, 2'b00, 1'b0, 0);
      run_burst(4'd9, 32'h0000_1000, 8'd255, 2'd1, 3'd3, 2'b00, 1'b0, 0);

      // Reset two beats into an 8-beat burst.
      run_burst(4'hA, 32'h0000_0300, 8'd7, 2'd1, 3'd3, 2'b00, 1'b0, 2);
      @(negedge clk);
      rst_i  = 1'b1;
      rready = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_rvalid", 64'(rvalid), 64'd0);
      check("midrst_arready", 64'(arready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_mem_en", 64'(mem_en), 64'd0);
      check("midrst_rdata", rdata, 64'd0);
      rst_i  = 1'b0;
      rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("after_rst_arready", 64'(arready), 64'd1);
         check("after_rst_rvalid", 64'(rvalid), 64'd0);
      end
      run_burst(4'hB, 32'h0000_0040, 8'd0, 2'd1, 3'd3, 2'b00, 1'b0, 0);
      @(negedge clk);
      #1;
      check("final_arready", 64'(arready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
